hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised data-hazard unit for the in-order RISC-V pipeline. It generalises the single-cycle load-use stall check into a scoreboard of per-register countdown counters. Multi-cycle producers (loads, M-extension multiplies) can therefore hold a consumer for a configurable number of cycles. It sits beside the decode stage: it watches the instruction being issued from D and the instruction waiting in F, drives the F/D stall, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- NUM_REGS, 32, architectural registers tracked; x0 is never tracked.
- LOAD_LAT, 2, cycles from load issue until its result is forwardable; 1 = no bubble, 2 = one bubble.
- MUL_LAT, 3, same for opcode 0110011 with funct7 0000001.
- STAT_W, 16, width of the stall statistics counter.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- instF_i  input  32  consumer instruction in F, next to issue.
- instD_i  input  32  producer instruction in D.
- issue_valid_i  input  1  instD_i advances to EX this cycle.
- flush_i  input  1  squash of F/D (taken branch or jump resolved in EX).
- clr_stats_i  input  1  synchronous clear of stall_count_o.
- need_stall_o  output  1  hold F/D and insert a bubble into EX.
- busy_o  output  1  at least one counter is nonzero.
- stall_count_o  output  STAT_W  saturating count of stalled cycles.

## Operation
- **State:** pend_q[r] for r = 1..NUM_REGS-1, width CW = $clog2(max(LOAD_LAT, MUL_LAT)); stat_q.
- **Producer latency L:**
  - load (0000011) → L = LOAD_LAT.
  - mul/div (0110011, funct7 0000001) → L = MUL_LAT.
  - anything else → no allocation (ALU results are forwarded).
- **Allocation:** when issue_valid_i=1, flush_i=0, L≥2 and rd≠0, pend_q[rd] loads L-2.
  - Allocation overrides the decrement and any existing value, including a WAW on a pending register.
- **Decrement:** every other nonzero pend_q decrements by 1 each cycle. Counters never wrap below 0.
- **Consumer source usage, decoded from instF_i opcode:**
  - rs1 used by all except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 used only by R (0110011), S (0100011) and B (1100011).
  - Unused sources and x0 never cause a stall.
- **Hit sources:**
  - hit_pend: a used rs has pend_q[rs]≠0.
  - hit_issue: issue_valid_i=1, the D producer has L≥2, its rd≠0, and rd equals a used rs.
- **Stall:** need_stall_o = (hit_pend | hit_issue) & ~flush_i. This is combinational.
- **Net effect:** a consumer directly behind a producer of latency L stalls exactly L-1 cycles.
- **Flush:**
  - Does not clear pend_q, because the producers are older than the branch.
  - Only suppresses same-cycle allocation and masks the stall.
- **Statistics:** stat_q increments each cycle need_stall_o=1, saturating at all-ones.
  - clr_stats_i has priority over the increment.
- **Reset:** all pend_q = 0, stat_q = 0.
  - need_stall_o and busy_o are 0 during and after reset until the first allocation.
  - Assertion mid-operation discards all pending entries immediately.

## Timing
- need_stall_o is combinational from instF_i, instD_i, issue_valid_i, flush_i and registered pend_q.
- Zero-cycle response to a same-cycle D producer.
- Counter updates, busy_o and stall_count_o are registered, with 1-cycle latency from the causing event.
- Example with LOAD_LAT=3, load to x5 issued in cycle t and consumer using x5 in F:
  - stall in t (hit_issue);
  - stall in t+1 (pend=1);
  - pend=0 at t+2, consumer issues.
- Stall being asserted while issue_valid_i=1 is legal: the producer leaves D while the consumer is held in F.

## Structure
- Shared package hazard_pkg holds:
  - opcode localparams (OP_LOAD, OP_OP, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL);
  - FUNCT7_MULDIV;
  - functions uses_rs1(inst), uses_rs2(inst) and prod_lat(inst, LOAD_LAT, MUL_LAT).
- One sub-module, pend_counter: a single loadable down-counter with load/value/nonzero. Instantiate it in a generate loop over r = 1..NUM_REGS-1.
- The top level handles decode, hit logic and statistics.

## Test plan
- **Load-use, LOAD_LAT=2:** lw x5 issued, add x6,x5,x1 in F → need_stall_o=1 for exactly 1 cycle, stall_count_o=1.
- **Multiply latency, MUL_LAT=3:** mul x7 issued, sub x8,x2,x7 in F → stall 2 cycles; busy_o high for 1 cycle after issue.
- **Unused and zero sources:**
  - lw x0 then add x1,x0,x0 → no stall.
  - lw x5 then lui x5 in F → no stall.
  - lw x5 then addi x9,x3,x5-bits (rs2 field=5) → no stall.
- **Flush:** lw x5 issued with flush_i=1 → no allocation, need_stall_o=0, pend_q[5]=0 next cycle.
- **WAW overwrite:**
  - LOAD_LAT=2, MUL_LAT=4: mul x5 then lw x5 next cycle → pend_q[5] becomes 0.
  - Consumer of x5 then stalls only per the load.
- **Reset and saturation:**
  - rst_i asserted mid-stall → need_stall_o=0 and busy_o=0 immediately.
  - STAT_W=2 with 5 stall cycles → stall_count_o=3.
  - clr_stats_i → 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared decode helpers for the hazard scoreboard.
// Holds the RV32 opcode constants the scoreboard cares about, the M-extension
// funct7 marker, and small decode functions:
//   uses_rs1(inst)  - instruction reads its rs1 field
//   uses_rs2(inst)  - instruction reads its rs2 field
//   prod_lat(inst, load_lat, mul_lat) - producer latency, 0 for forwarded ALU ops
package hazard_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic uses_rs1(input logic [31:0] inst);
    return !(inst[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic logic uses_rs2(input logic [31:0] inst);
    return inst[6:0] inside {OP_OP, OP_STORE, OP_BRANCH};
  endfunction

  // Latency of a multi-cycle producer; 0 means the result is forwarded and
  // no scoreboard entry is needed.
  function automatic int prod_lat(input logic [31:0] inst, input int load_lat,
                                  input int mul_lat);
    if (inst[6:0] == OP_LOAD)
      return load_lat;
    else if (inst[6:0] == OP_OP && inst[31:25] == FUNCT7_MULDIV)
      return mul_lat;
    else
      return 0;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_pend_counter.sv
// pend_counter: one scoreboard entry, a loadable down-counter.
// Ports:
//   clk, rst (async, active-high)
//   load      - take load_val this cycle (wins over the decrement)
//   load_val  - value to load
//   value     - current count
//   nonzero   - value != 0
// The counter stops at zero, it never wraps.
module pend_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] value,
  output logic          nonzero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= '0;
    else if (load)
      value <= load_val;
    else if (value != '0)
      value <= value - 1'b1;
  end

  assign nonzero = |value;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: data-hazard unit beside the decode stage.
// Tracks multi-cycle producers (loads, mul/div) with one countdown counter per
// architectural register and stalls the consumer waiting in F until the
// producer's result is forwardable.
// Ports:
//   clk_i, rst_i (async, active-high)
//   instF_i        - consumer instruction in F
//   instD_i        - producer instruction in D
//   issue_valid_i  - instD_i advances to EX this cycle
//   flush_i        - F/D squash
//   clr_stats_i    - synchronous clear of stall_count_o
//   need_stall_o   - hold F/D, bubble into EX (combinational)
//   busy_o         - some counter is nonzero
//   stall_count_o  - saturating stalled-cycle count
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 3,
  parameter int STAT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instF_i,
  input  logic [31:0]       instD_i,
  input  logic              issue_valid_i,
  input  logic              flush_i,
  input  logic              clr_stats_i,
  output logic              need_stall_o,
  output logic              busy_o,
  output logic [STAT_W-1:0] stall_count_o
);

  localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
  // Keep at least one bit even when every producer has latency 1.
  localparam int CW = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

  logic [4:0]    rs1, rs2, rd_d;
  logic          use1, use2;
  int            lat_d;
  logic          prod_long;
  logic          alloc;
  logic [CW-1:0] alloc_val;
  logic          hit_pend, hit_issue;

  logic [NUM_REGS-1:0] pend_nz;
  logic [CW-1:0]       pend_val [NUM_REGS];

  assign rs1  = instF_i[19:15];
  assign rs2  = instF_i[24:20];
  assign rd_d = instD_i[11:7];
  assign use1 = uses_rs1(instF_i);
  assign use2 = uses_rs2(instF_i);

  assign lat_d     = prod_lat(instD_i, LOAD_LAT, MUL_LAT);
  assign prod_long = (lat_d >= 2) && (rd_d != 5'd0);
  assign alloc     = issue_valid_i && !flush_i && prod_long;
  // The same-cycle stall (hit_issue) already covers one bubble, so the
  // counter only has to cover the remaining L-2 cycles.
  assign alloc_val = CW'(lat_d - 2);

  // x0 is never tracked.
  assign pend_nz[0]  = 1'b0;
  assign pend_val[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_pend
      pend_counter #(.CW(CW)) u_cnt (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (alloc && (rd_d == 5'(gi))),
        .load_val (alloc_val),
        .value    (pend_val[gi]),
        .nonzero  (pend_nz[gi])
      );
    end
  endgenerate

  always_comb begin
    hit_pend = 1'b0;
    if (use1 && (int'(rs1) < NUM_REGS) && (pend_val[rs1] != '0))
      hit_pend = 1'b1;
    if (use2 && (int'(rs2) < NUM_REGS) && (pend_val[rs2] != '0))
      hit_pend = 1'b1;
  end

  assign hit_issue = issue_valid_i && prod_long &&
                     ((use1 && rs1 == rd_d) || (use2 && rs2 == rd_d));

  // Masked by reset so a same-cycle D producer cannot stall while in reset.
  assign need_stall_o = (hit_pend || hit_issue) && !flush_i && !rst_i;
  assign busy_o       = |pend_nz;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_count_o <= '0;
    else if (clr_stats_i)
      stall_count_o <= '0;
    else if (need_stall_o && (stall_count_o != '1))
      stall_count_o <= stall_count_o + 1'b1;
  end

endmodule
